// File: rtl/lcd_text_controller_if.sv
// Byte-stream handshake between the UART receiver and the LCD text controller.
interface lcd_text_controller_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/lcd_text_controller.sv
// HD44780 text controller: runs power-up init, then turns an ASCII byte stream into LCD
// writes with cursor tracking, line wrap, CR, LF and backspace, on an 8-bit or 4-bit bus.
module lcd_text_controller #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned BUS4       = 0,
    parameter int unsigned T_E_NS     = 500,
    parameter int unsigned T_CMD_US   = 50,
    parameter int unsigned T_CLR_US   = 2000,
    parameter int unsigned T_PWRUP_US = 15000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lcd_text_controller_if.slave    in_if,
    output logic                    lcd_rs,
    output logic                    lcd_rw,
    output logic                    lcd_e,
    output logic [7:0]              lcd_db,
    output logic                    busy,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    cur_row
);
    localparam int unsigned     ColW = $clog2(COLS);
    localparam longint unsigned Hz   = 64'(CLK_HZ);

    localparam longint unsigned E_CYC   = (Hz * 64'(T_E_NS) + 64'd999_999_999) / 64'd1_000_000_000;
    localparam longint unsigned CMD_CYC = (Hz * 64'(T_CMD_US) + 64'd999_999) / 64'd1_000_000;
    localparam longint unsigned CLR_CYC = (Hz * 64'(T_CLR_US) + 64'd999_999) / 64'd1_000_000;
    localparam longint unsigned PWR_CYC = (Hz * 64'(T_PWRUP_US) + 64'd999_999) / 64'd1_000_000;

    localparam longint unsigned MaxA   = (E_CYC > CMD_CYC) ? E_CYC : CMD_CYC;
    localparam longint unsigned MaxB   = (CLR_CYC > PWR_CYC) ? CLR_CYC : PWR_CYC;
    localparam longint unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned     TmrW   = $clog2(MaxCyc + 1);

    localparam logic [TmrW-1:0] ELoad   = TmrW'(E_CYC - 1);
    localparam logic [TmrW-1:0] CmdLoad = TmrW'(CMD_CYC - 1);
    localparam logic [TmrW-1:0] ClrLoad = TmrW'(CLR_CYC - 1);
    localparam logic [TmrW-1:0] PwrLoad = TmrW'(PWR_CYC - 1);

    localparam logic [3:0] InitLen = (BUS4 != 0) ? 4'd9 : 4'd5;

    typedef enum logic [2:0] {StPwrup, StPwrWait, StRun, StIdle, StDecode} main_st_e;
    typedef enum logic [2:0] {TxIdle, TxSetup, TxEhi, TxElo, TxWait} tx_st_e;

    main_st_e          main_q, main_d;
    tx_st_e            tx_q, tx_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [3:0]        step_q, step_d, len_q, len_d;
    logic              init_q, init_d;
    logic [3:0][7:0]   act_byte_q, act_byte_d;
    logic [3:0]        act_rs_q, act_rs_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_rs_q, tx_rs_d;
    logic              tx_nib_q, tx_nib_d;
    logic              lo_q, lo_d;
    logic [ColW-1:0]   col_q, col_d;
    logic              row_q, row_d;

    logic              launch;
    logic [9:0]        launch_entry;
    logic              go;
    logic [ColW-1:0]   bs_col;
    logic              bs_row;
    logic              tx_fin;
    logic              nxt_row;
    logic [3:0]        step_nx;

    // Entry layout: {nibble_only, rs, byte}; BUS4=0 skips the four nibble-only entries.
    function automatic logic [9:0] init_entry(input logic [3:0] idx);
        logic [3:0] k;
        logic [7:0] fset;
        fset = ((BUS4 != 0) ? 8'h20 : 8'h30) | ((ROWS > 1) ? 8'h08 : 8'h00);
        k    = (BUS4 != 0) ? idx : idx + 4'd4;
        case (k)
            4'd0, 4'd1, 4'd2: init_entry = {2'b10, 8'h30};
            4'd3:             init_entry = {2'b10, 8'h20};
            4'd4:             init_entry = {2'b00, fset};
            4'd5:             init_entry = {2'b00, 8'h0C};
            4'd6:             init_entry = {2'b00, 8'h01};
            4'd7:             init_entry = {2'b00, 8'h06};
            default:          init_entry = {2'b00, 8'h80};
        endcase
    endfunction

    function automatic logic [7:0] set_addr(input logic row, input logic [ColW-1:0] col);
        set_addr = {1'b1, row, 6'(col)};
    endfunction

    assign tx_fin  = (tx_q == TxWait) && (timer_q == '0);
    assign nxt_row = (ROWS > 1) ? ~row_q : 1'b0;
    assign step_nx = step_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= StPwrup;
            tx_q       <= TxIdle;
            timer_q    <= '0;
            step_q     <= '0;
            len_q      <= '0;
            init_q     <= 1'b0;
            act_byte_q <= '0;
            act_rs_q   <= '0;
            byte_q     <= '0;
            tx_byte_q  <= '0;
            tx_rs_q    <= 1'b0;
            tx_nib_q   <= 1'b0;
            lo_q       <= 1'b0;
            col_q      <= '0;
            row_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            tx_q       <= tx_d;
            timer_q    <= timer_d;
            step_q     <= step_d;
            len_q      <= len_d;
            init_q     <= init_d;
            act_byte_q <= act_byte_d;
            act_rs_q   <= act_rs_d;
            byte_q     <= byte_d;
            tx_byte_q  <= tx_byte_d;
            tx_rs_q    <= tx_rs_d;
            tx_nib_q   <= tx_nib_d;
            lo_q       <= lo_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    always_comb begin
        main_d       = main_q;
        tx_d         = tx_q;
        timer_d      = timer_q;
        step_d       = step_q;
        len_d        = len_q;
        init_d       = init_q;
        act_byte_d   = act_byte_q;
        act_rs_d     = act_rs_q;
        byte_d       = byte_q;
        tx_byte_d    = tx_byte_q;
        tx_rs_d      = tx_rs_q;
        tx_nib_d     = tx_nib_q;
        lo_d         = lo_q;
        col_d        = col_q;
        row_d        = row_q;
        launch       = 1'b0;
        launch_entry = '0;
        go           = 1'b0;
        bs_col       = col_q;
        bs_row       = row_q;

        case (tx_q)
            TxSetup: begin
                tx_d    = TxEhi;
                timer_d = ELoad;
            end
            TxEhi: begin
                if (timer_q == '0) begin
                    tx_d    = TxElo;
                    timer_d = ELoad;
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            TxElo: begin
                if (timer_q == '0) begin
                    if (BUS4 != 0 && !tx_nib_q && !lo_q) begin
                        lo_d = 1'b1;
                        tx_d = TxSetup;
                    end else begin
                        tx_d    = TxWait;
                        timer_d = (!tx_nib_q && !tx_rs_q && tx_byte_q == 8'h01) ? ClrLoad : CmdLoad;
                    end
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            TxWait: begin
                if (timer_q == '0) tx_d = TxIdle;
                else               timer_d = timer_q - TmrW'(1);
            end
            default: ;
        endcase

        case (main_q)
            StPwrup: begin
                timer_d = PwrLoad;
                main_d  = StPwrWait;
            end
            StPwrWait: begin
                if (timer_q == '0) begin
                    init_d       = 1'b1;
                    step_d       = '0;
                    len_d        = InitLen;
                    launch       = 1'b1;
                    launch_entry = init_entry(4'd0);
                    main_d       = StRun;
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            StRun: begin
                // Chain the next write straight off the last wait cycle of the previous one.
                if (tx_fin) begin
                    if (step_nx < len_q) begin
                        step_d       = step_nx;
                        launch       = 1'b1;
                        launch_entry = init_q ? init_entry(step_nx)
                                              : {1'b0, act_rs_q[step_nx[1:0]],
                                                 act_byte_q[step_nx[1:0]]};
                    end else begin
                        main_d = StIdle;
                    end
                end
            end
            StIdle: begin
                if (in_if.in_valid) begin
                    byte_d = in_if.in_data;
                    main_d = StDecode;
                end
            end
            StDecode: begin
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    go            = 1'b1;
                    act_byte_d[0] = byte_q;
                    act_rs_d[0]   = 1'b1;
                    if (col_q == ColW'(COLS - 1)) begin
                        col_d         = '0;
                        row_d         = nxt_row;
                        act_byte_d[1] = set_addr(nxt_row, '0);
                        act_rs_d[1]   = 1'b0;
                        len_d         = 4'd2;
                    end else begin
                        col_d = col_q + ColW'(1);
                        len_d = 4'd1;
                    end
                end else if (byte_q == 8'h0D) begin
                    go            = 1'b1;
                    act_byte_d[0] = 8'h01;
                    act_rs_d[0]   = 1'b0;
                    len_d         = 4'd1;
                    col_d         = '0;
                    row_d         = 1'b0;
                end else if (byte_q == 8'h0A) begin
                    go            = 1'b1;
                    act_byte_d[0] = set_addr(nxt_row, '0);
                    act_rs_d[0]   = 1'b0;
                    len_d         = 4'd1;
                    col_d         = '0;
                    row_d         = nxt_row;
                end else if (byte_q == 8'h08) begin
                    if (col_q != '0) begin
                        go     = 1'b1;
                        bs_col = col_q - ColW'(1);
                        bs_row = row_q;
                    end else if (ROWS > 1 && row_q) begin
                        go     = 1'b1;
                        bs_col = ColW'(COLS - 1);
                        bs_row = 1'b0;
                    end
                    // Blank the cell by overwriting it, then park the cursor back on it.
                    if (go) begin
                        col_d         = bs_col;
                        row_d         = bs_row;
                        act_byte_d[0] = set_addr(bs_row, bs_col);
                        act_rs_d[0]   = 1'b0;
                        act_byte_d[1] = 8'h20;
                        act_rs_d[1]   = 1'b1;
                        act_byte_d[2] = set_addr(bs_row, bs_col);
                        act_rs_d[2]   = 1'b0;
                        len_d         = 4'd3;
                    end
                end
                init_d = 1'b0;
                step_d = '0;
                if (go) begin
                    launch       = 1'b1;
                    launch_entry = {1'b0, act_rs_d[0], act_byte_d[0]};
                    main_d       = StRun;
                end else begin
                    main_d = StIdle;
                end
            end
            default: main_d = StPwrup;
        endcase

        if (launch) begin
            tx_d      = TxSetup;
            tx_byte_d = launch_entry[7:0];
            tx_rs_d   = launch_entry[8];
            tx_nib_d  = launch_entry[9];
            lo_d      = 1'b0;
        end
    end

    assign lcd_rw         = 1'b0;
    assign lcd_e          = (tx_q == TxEhi);
    assign lcd_rs         = tx_rs_q;
    assign lcd_db         = (BUS4 != 0) ? {(lo_q ? tx_byte_q[3:0] : tx_byte_q[7:4]), 4'h0}
                                        : tx_byte_q;
    assign busy           = (main_q != StIdle);
    assign in_if.in_ready = (main_q == StIdle);
    assign cur_col        = col_q;
    assign cur_row        = row_q;
endmodule
